// File: rtl/CPU_pkg.sv
// CPU_pkg: shared CPU constants, issue channel indices and decoded payload layout
package CPU_pkg;
   localparam int CH_MAIN = 0;
   localparam int CH_MUL = 1;
   localparam int CH_DIV = 2;
   localparam int CH_FPU = 3;
   localparam int ISSUE_DEPTH = 2;
   typedef struct packed {
      logic [31:0]  pc;
      logic [6:0]   opcode;
      logic [2:0]   funct3;
      logic [6:0]   funct7;
      logic [4:0]   rd;
      logic [31:0]  rs1_val;
      logic [31:0]  rs2_val;
      logic [31:0]  rs3_val;
      logic [31:0]  imm;
      logic [11:0]  csr_addr;
      logic [37:0]  ctrl;
   } decoded_t;
endpackage

// File: rtl/issue_fifo_mem.sv
// issue_fifo_mem: issue buffer storage, registered write and combinational read
module issue_fifo_mem import CPU_pkg::*; #(
   parameter int W = 8,
   parameter int DEPTH = ISSUE_DEPTH
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [W-1:0]             wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [W-1:0]             rdata
);
   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] mem_d [DEPTH];
   // write the incoming entry into its slot
   always_comb begin
      mem_d = mem_q;
      if (we) mem_d[waddr] = wdata;
   end
   // storage has no reset; readers gate on occupancy
   always_ff @(posedge clk) mem_q <= mem_d;
   assign rdata = mem_q[raddr];
endmodule

// File: rtl/issue_fork_buffer.sv
// issue_fork_buffer: decode-to-issue FIFO forking the head to a mask of consumer channels
module issue_fork_buffer import CPU_pkg::*; #(
   parameter int WIDTH = 256,
   parameter int CH = 4,
   parameter int DEPTH = ISSUE_DEPTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       valid_in,
   output logic                       ready_out,
   input  logic [WIDTH-1:0]           data_in,
   input  logic [CH-1:0]              sel_in,
   input  logic                       serial_in,
   input  logic                       serial_done,
   output logic [CH-1:0]              valid_out,
   input  logic [CH-1:0]              ready_in,
   output logic [WIDTH-1:0]           data_out,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   logic [AW-1:0]       wp_q, wp_d, rp_q, rp_d;
   logic [CW-1:0]       count_q, count_d;
   logic [CH-1:0]       acked_q, acked_d, head_sel, hs;
   logic                lock_q, lock_d, lock, head_valid, push, pop;
   logic [WIDTH-1:0]    head_data;
   logic [WIDTH+CH-1:0] rd_entry;
   issue_fifo_mem #(.W(WIDTH+CH), .DEPTH(DEPTH)) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wp_q),
      .wdata ({sel_in | CH'(1 << CH_MAIN), data_in}),
      .raddr (rp_q),
      .rdata (rd_entry)
   );
   assign {head_sel, head_data} = rd_entry;
   assign head_valid = count_q != '0;
   // a release pulse reopens the input in the same cycle it arrives
   assign lock = lock_q && !serial_done;
   assign ready_out = (count_q != CW'(DEPTH)) && !lock && !flush;
   assign push = valid_in && ready_out;
   assign valid_out = (head_valid && !flush) ? head_sel & ~acked_q : '0;
   assign hs = valid_out & ready_in;
   assign pop = head_valid && !flush && ((head_sel & ~(acked_q | hs)) == '0);
   assign data_out = head_valid ? head_data : '0;
   assign count = count_q;
   // pointer, occupancy, per-channel ack and serialisation lock updates
   always_comb begin
      wp_d = flush ? '0 : wp_q + AW'(push);
      rp_d = flush ? '0 : rp_q + AW'(pop);
      count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
      acked_d = (flush || pop) ? '0 : acked_q | hs;
      lock_d = flush ? 1'b0 : (push && serial_in) ? 1'b1 : lock;
   end
   // state registers with asynchronous reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wp_q <= '0;
         rp_q <= '0;
         count_q <= '0;
         acked_q <= '0;
         lock_q <= 1'b0;
      end else begin
         wp_q <= wp_d;
         rp_q <= rp_d;
         count_q <= count_d;
         acked_q <= acked_d;
         lock_q <= lock_d;
      end
   end
endmodule
